// File: rtl/sii9136_vid_gen.sv
// Raster timing and test-pattern source for the SiI9136 parallel input bus.
// Each output is registered from the counter state, so the outputs trail the counters by one clock.
module sii9136_vid_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [35:0] solid_rgb,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic [35:0] d,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // The pattern logic reads h_cnt[7:0] and v_cnt[5], so the counters need at least that many bits
   localparam int HW      = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
   localparam int VW      = ($clog2(V_TOTAL) > 6) ? $clog2(V_TOTAL) : 6;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int SW      = ($clog2(BAR_W) > 0) ? $clog2(BAR_W) : 1;
   localparam logic HS_ACT = (HS_POL != 0);
   localparam logic VS_ACT = (VS_POL != 0);

   logic [HW-1:0] r_hCnt;
   logic [VW-1:0] r_vCnt;
   logic [SW-1:0] r_segCnt;
   logic [2:0]    r_barIdx;
   logic [1:0]    r_activeSel;
   logic          r_de;
   logic          r_hsync;
   logic          r_vsync;
   logic [35:0]   r_d;
   logic          r_frameStart;

   logic          w_lineEnd;
   logic          w_frameEnd;
   logic          w_frameOrigin;
   logic          w_active;
   logic          w_hsAct;
   logic          w_vsAct;
   logic [1:0]    w_sel;
   logic [11:0]   w_gray;
   logic [35:0]   w_pixel;

   assign w_lineEnd     = (r_hCnt == HW'(H_TOTAL - 1));
   assign w_frameEnd    = w_lineEnd && (r_vCnt == VW'(V_TOTAL - 1));
   assign w_frameOrigin = (r_hCnt == '0) && (r_vCnt == '0);
   assign w_active      = (r_hCnt < HW'(H_ACTIVE)) && (r_vCnt < VW'(V_ACTIVE));
   assign w_hsAct       = (r_hCnt >= HW'(H_ACTIVE + H_FP)) &&
                          (r_hCnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
   assign w_vsAct       = (r_vCnt >= VW'(V_ACTIVE + V_FP)) &&
                          (r_vCnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
   // Pixel (0,0) must already use the newly latched selection
   assign w_sel         = w_frameOrigin ? pattern_sel : r_activeSel;
   assign w_gray        = {r_hCnt[7:0], r_hCnt[7:4]};

   always_comb begin
      w_pixel = '0;
      unique case (w_sel)
         2'd0:    w_pixel = {{12{~r_barIdx[1]}}, {12{~r_barIdx[2]}}, {12{~r_barIdx[0]}}};
         2'd1:    w_pixel = {36{r_hCnt[5] ^ r_vCnt[5]}};
         2'd2:    w_pixel = {w_gray, w_gray, w_gray};
         default: w_pixel = solid_rgb;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_hCnt       <= '0;
         r_vCnt       <= '0;
         r_segCnt     <= '0;
         r_barIdx     <= '0;
         r_de         <= 1'b0;
         r_d          <= '0;
         r_hsync      <= ~HS_ACT;
         r_vsync      <= ~VS_ACT;
         r_frameStart <= 1'b0;
         if (reset) begin
            r_activeSel <= '0;
         end
      end else begin
         if (w_frameOrigin) begin
            r_activeSel <= pattern_sel;
         end
         r_de         <= w_active;
         r_d          <= w_active ? w_pixel : '0;
         r_hsync      <= w_hsAct ? HS_ACT : ~HS_ACT;
         r_vsync      <= w_vsAct ? VS_ACT : ~VS_ACT;
         r_frameStart <= w_frameOrigin;

         if (w_frameEnd) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
         end else if (w_lineEnd) begin
            r_hCnt <= '0;
            r_vCnt <= r_vCnt + 1'b1;
         end else begin
            r_hCnt <= r_hCnt + 1'b1;
         end

         // Bar index tracks h_cnt in BAR_W-pixel segments, which avoids a divider
         if (w_lineEnd) begin
            r_segCnt <= '0;
            r_barIdx <= '0;
         end else if (r_segCnt == SW'(BAR_W - 1)) begin
            r_segCnt <= '0;
            r_barIdx <= r_barIdx + 1'b1;
         end else begin
            r_segCnt <= r_segCnt + 1'b1;
         end
      end
   end

   assign de          = r_de;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign d           = r_d;
   assign frame_start = r_frameStart;

endmodule

// File: tb/tb_sii9136_vid_gen.sv
// Scoreboard bench for sii9136_vid_gen: a reference model queues the expected output for every clock,
// and a monitor on the falling edge compares each queued entry against the DUT.
module tb_sii9136_vid_gen;

   localparam int HA = 128;
   localparam int HF = 4;
   localparam int HS = 8;
   localparam int HB = 4;
   localparam int VA = 40;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam bit HSP = 1'b0;
   localparam bit VSP = 1'b1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  patternSel = 2'd0;
   logic [35:0] solidRgb = 36'd0;
   logic        de;
   logic        hsync;
   logic        vsync;
   logic [35:0] d;
   logic        frameStart;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [35:0] d;
   } pixT;

   pixT expQ[$];
   pixT modelExp;
   int  testsRun = 0;
   int  testsFailed = 0;
   int  modelK = 0;
   int  modelSel = 0;

   sii9136_vid_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(int'(HSP)), .VS_POL(int'(VSP))
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .pattern_sel(patternSel),
      .solid_rgb(solidRgb),
      .de(de),
      .hsync(hsync),
      .vsync(vsync),
      .d(d),
      .frame_start(frameStart)
   );

   always #5 clk = ~clk;

   function automatic pixT idlePix();
      pixT p;
      p.de = 1'b0;
      p.hs = ~HSP;
      p.vs = ~VSP;
      p.fs = 1'b0;
      p.d  = 36'd0;
      return p;
   endfunction

   // Expected output for the k-th pixel since the raster (re)started
   function automatic pixT refPixel(int k, int sel, logic [35:0] rgb);
      pixT        p;
      int         h;
      int         v;
      int         bar;
      int         g;
      logic [2:0] on;
      logic [11:0] gray;
      h = k % HT;
      v = (k / HT) % VT;
      p.de = (h < HA) && (v < VA);
      p.hs = (h >= HA + HF && h < HA + HF + HS) ? HSP : ~HSP;
      p.vs = (v >= VA + VF && v < VA + VF + VS) ? VSP : ~VSP;
      p.fs = (h == 0) && (v == 0);
      p.d  = 36'd0;
      if (p.de) begin
         case (sel)
            0: begin
               bar = h / (HA / 8);
               case (bar)
                  0: on = 3'b111;
                  1: on = 3'b110;
                  2: on = 3'b011;
                  3: on = 3'b010;
                  4: on = 3'b101;
                  5: on = 3'b100;
                  6: on = 3'b001;
                  default: on = 3'b000;
               endcase
               p.d = {{12{on[2]}}, {12{on[1]}}, {12{on[0]}}};
            end
            1: p.d = (((h / 32) % 2) != ((v / 32) % 2)) ? {36{1'b1}} : 36'd0;
            2: begin
               g = (h % 256) * 16 + (h % 256) / 16;
               gray = 12'(g);
               p.d = {gray, gray, gray};
            end
            default: p.d = rgb;
         endcase
      end
      return p;
   endfunction

   // Reference model: one expected output per rising edge
   always @(posedge clk) begin
      if (reset) begin
         modelExp = idlePix();
         modelK   = 0;
         modelSel = 0;
      end else if (!enable) begin
         modelExp = idlePix();
         modelK   = 0;
      end else begin
         if (modelK % FRAME == 0) begin
            modelSel = int'(patternSel);
         end
         modelExp = refPixel(modelK, modelSel, solidRgb);
         modelK++;
      end
      expQ.push_back(modelExp);
   end

   task automatic checkOutput(input pixT e);
      pixT a;
      a = {de, hsync, vsync, frameStart, d};
      testsRun++;
      if (a !== e) begin
         testsFailed++;
         $display("[TB] FAIL pixel t=%0t got de=%b hs=%b vs=%b fs=%b d=%h, expected de=%b hs=%b vs=%b fs=%b d=%h",
                  $time, a.de, a.hs, a.vs, a.fs, a.d, e.de, e.hs, e.vs, e.fs, e.d);
      end
   endtask

   // Monitor: compare on the falling edge, away from the register update
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] sel,
                                input logic [35:0] rgb, input int cycles);
      reset      = rst;
      enable     = en;
      patternSel = sel;
      solidRgb   = rgb;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      logic [35:0] rndRgb;
      // Reset with enable high, then color bars for part of a frame
      applyStimulus(1'b1, 1'b1, 2'd0, 36'd0, 3);
      applyStimulus(1'b0, 1'b1, 2'd0, 36'd0, 2000);
      // Mid-frame switch to solid; bars continue until the next frame origin
      applyStimulus(1'b0, 1'b1, 2'd3, 36'h123456789, 2 * FRAME);
      // Ramp, enable dropped at line 10 pixel 30 for 10 cycles, then restart
      applyStimulus(1'b1, 1'b1, 2'd2, 36'd0, 1);
      applyStimulus(1'b0, 1'b1, 2'd2, 36'd0, 10 * HT + 30);
      applyStimulus(1'b0, 1'b0, 2'd2, 36'd0, 10);
      applyStimulus(1'b0, 1'b1, 2'd2, 36'd0, 300);
      // Randomized segments: pattern, color, enable and reset
      for (int i = 0; i < 15; i++) begin
         rndRgb[31:0]  = $urandom;
         rndRgb[35:32] = 4'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
                       2'($urandom_range(0, 3)), rndRgb, $urandom_range(1, 2500));
      end
      applyStimulus(1'b0, 1'b0, 2'd0, 36'd0, 3);
      #2;
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: %0d entries left in queue, expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/sii9136_vid_gen.md
# sii9136_vid_gen

Video timing and test-pattern generator that drives the SiI9136 HDMI transmitter's parallel input bus (de, hsync, vsync, 36-bit d). It is the source end of the same DE/HSYNC/VSYNC/36-bit pixel interface that the SiI9233 receiver presents to the FPGA. It produces a complete raster with selectable test patterns, so the transmit path can be brought up without a live input. It runs in the pixel clock domain; idck forwarding and I2C configuration of the SiI9136 are handled outside this block.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line; must be a multiple of 8.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, active lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- HS_POL, 0, active level of hsync (0 = active-low).
- VS_POL, 0, active level of vsync (0 = active-low).

Ports:
- clk  in  1  pixel clock; one clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run raster when high.
- pattern_sel  in  2  0 color bars, 1 checkerboard, 2 gray ramp, 3 solid.
- solid_rgb  in  36  color used for pattern 3.
- de  out  1  data enable to SiI9136.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- d  out  36  pixel data: R = d[35:24], G = d[23:12], B = d[11:0].
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0) on the outputs.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at default).
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. de is high there and low elsewhere.
- hsync is at its active level for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
- vsync is at its active level for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. Its transitions occur at h_cnt = 0.
- d is 0 whenever de is low.
- Patterns, selected by active_sel:
  - Color bars: 8 bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. Each channel is 12'hFFF or 12'h000. The bar index comes from a per-line segment counter; no divider.
  - Checkerboard: white when h_cnt[5]^v_cnt[5], otherwise black (32-pixel squares).
  - Gray ramp: R = G = B = {h_cnt[7:0], h_cnt[7:4]}; repeats every 256 pixels.
  - Solid: d = solid_rgb.
- pattern_sel is latched into active_sel only when h_cnt = 0 and v_cnt = 0, so there is no mid-frame tearing. active_sel resets to 0.
- When enable is low, counters are forced to (0,0) and outputs are idle. Idle means de = 0, d = 0, frame_start = 0, hsync = ~HS_POL, vsync = ~VS_POL.

## Timing
- Reset values (registered outputs, one cycle after reset is sampled high): de = 0, d = 0, frame_start = 0, hsync = ~HS_POL, vsync = ~VS_POL, counters = (0,0), active_sel = 0.
- Latency: all outputs are registered from the counter state. Counter state at edge N appears on the outputs after edge N+1. de, hsync, vsync, d and frame_start are mutually cycle-aligned.
- The first enabled edge with reset low has counter state (0,0). The next cycle shows pixel (0,0): de = 1 and frame_start = 1.
- frame_start is high exactly once per V_TOTAL*H_TOTAL cycles while enable stays high.
- enable falling mid-line: outputs go idle on the next cycle. On re-enable, timing restarts at (0,0).
- reset high mid-frame: same effect as enable falling, plus active_sel clears to 0.
- Simultaneous reset and enable: reset wins.
- Wrap: at h_cnt = H_TOTAL-1 with v_cnt = V_TOTAL-1, both counters go to 0 on the same edge.

## Test plan
- Reset held 3 cycles, enable = 1 -> during reset de = 0, d = 0, hsync = 1, vsync = 1. After release, frame_start and de rise together one cycle after the first enabled edge.
- Line timing, defaults -> de high 640 consecutive cycles; hsync low 96 cycles starting 16 cycles after de falls; period 800 cycles.
- Frame timing -> 480 lines with de; vsync low for lines 490–491 (1600 cycles); frame_start period 420000 cycles.
- Color bars, line 0 -> pixel 0 = FFF/FFF/FFF; pixel 80 = FFF/FFF/000; pixel 400 = FFF/000/000; pixel 639 = 000/000/000.
- pattern_sel changed 0→3 mid-frame, solid_rgb = 36'h123456789 -> the rest of the frame stays bars; the next frame's pixel (0,0) is 36'h123456789.
- enable dropped at line 100, pixel 300, then raised 10 cycles later -> idle outputs on the next cycle; the new frame_start arrives one cycle after the first enabled edge; ramp pattern pixel 17 = 12'h111 per channel.
